decodificador_hora: RTL and testbench

//  Inverse of the hour formatter: accepts an 8-bit packed BCD hour byte (12h or 24h format,
//  e.g. read back from the RTC or entered by the user) and converts it to the 5-bit binary
//  24h hour (0..23) that loads the hour counter. Multi-cycle FSM with valid/ready input

---
 rtl/decodificador_hora.sv | 117 +++++++++++
 tb/tb_decodificador_hora.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_hora.sv
// Converts a packed BCD hour byte (12h or 24h form) into a binary 24h hour for the
// hour counter's load port, with digit/range validation and one-cycle done/error pulses.
module decodificador_hora #(
    parameter logic [4:0] HORA_RST = 5'd0,
    parameter logic       PM_RST   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] hora_in_i,
    output logic [4:0] hora_bin_o,
    output logic       pm_o,
    output logic       hora_ok_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StConvert,
        StMap,
        StDone,
        StError
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] byte_q, byte_d;
    logic [4:0] val_q, val_d;
    logic [4:0] hora_bin_q, hora_bin_d;
    logic       pm_q, pm_d;
    logic       hora_ok_q, err_q;

    logic       mode12, pm_flag, digit_bad, range_bad;
    logic [1:0] tens;
    logic [3:0] units;
    logic [4:0] tens_w, val_calc, mapped;
    logic       unused_bit7;

    // Bit 7 of the input byte carries no meaning in either format.
    assign unused_bit7 = hora_in_i[7];

    assign mode12    = byte_q[6];
    assign pm_flag   = byte_q[5];
    assign tens      = mode12 ? {1'b0, byte_q[4]} : byte_q[5:4];
    assign units     = byte_q[3:0];
    assign tens_w    = {3'b000, tens};
    assign val_calc  = (tens_w << 3) + (tens_w << 1) + {1'b0, units};
    assign digit_bad = (units > 4'd9) || (!mode12 && tens > 2'd2) || (mode12 && tens > 2'd1);
    assign range_bad = mode12 ? ((val_calc == 5'd0) || (val_calc > 5'd12)) : (val_calc > 5'd23);

    always_comb begin
        mapped = val_q;
        if (mode12) begin
            if (pm_flag) begin
                mapped = (val_q == 5'd12) ? 5'd12 : val_q + 5'd12;
            end else begin
                mapped = (val_q == 5'd12) ? 5'd0 : val_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        val_d      = val_q;
        hora_bin_d = hora_bin_q;
        pm_d       = pm_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    byte_d  = hora_in_i[6:0];
                    state_d = StCapture;
                end
            end
            StCapture: state_d = digit_bad ? StError : StConvert;
            StConvert: begin
                val_d   = val_calc;
                state_d = range_bad ? StError : StMap;
            end
            StMap: begin
                hora_bin_d = mapped;
                pm_d       = (mapped >= 5'd12);
                state_d    = StDone;
            end
            StDone, StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            byte_q     <= '0;
            val_q      <= '0;
            hora_bin_q <= HORA_RST;
            pm_q       <= PM_RST;
            hora_ok_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            val_q      <= val_d;
            hora_bin_q <= hora_bin_d;
            pm_q       <= pm_d;
            hora_ok_q  <= (state_d == StDone);
            err_q      <= (state_d == StError);
        end
    end

    assign in_ready_o = (state_q == StIdle);
    assign hora_bin_o = hora_bin_q;
    assign pm_o       = pm_q;
    assign hora_ok_o  = hora_ok_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_decodificador_hora.sv
// Bench for decodificador_hora: schedule-based reference model compared every cycle,
// plus directed literal expectations for the documented hour conversions.
module tb_decodificador_hora;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] hora_in;
    logic [4:0] hora_bin;
    logic       pm;
    logic       hora_ok;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decodificador_hora #(
        .HORA_RST(5'd0),
        .PM_RST  (1'b0)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .hora_in_i (hora_in),
        .hora_bin_o(hora_bin),
        .pm_o      (pm),
        .hora_ok_o (hora_ok),
        .err_o     (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 accepted, 1 bad digit, 2 out of range
    function automatic void decode(input logic [7:0] b, output int kind, output int hour);
        int t, u, v;
        bit h12;
        h12  = b[6];
        u    = int'(b[3:0]);
        t    = h12 ? int'(b[4]) : int'(b[5:4]);
        hour = 0;
        kind = 0;
        if (u > 9 || (!h12 && t > 2)) begin
            kind = 1;
        end else begin
            v = t * 10 + u;
            if (h12 ? (v == 0 || v > 12) : (v > 23)) begin
                kind = 2;
            end else if (!h12) begin
                hour = v;
            end else if (b[5]) begin
                hour = (v == 12) ? 12 : v + 12;
            end else begin
                hour = (v == 12) ? 0 : v;
            end
        end
    endfunction

    // Reference model: each accepted byte schedules its outcome a fixed number of edges later.
    int         cyc = 0;
    bit         started = 1'b0;
    bit         m_ready, m_ok, m_err, m_pm, m_pend, m_pend_ok;
    logic [4:0] m_bin;
    int         m_ev_at, m_ready_at, m_pend_hour;

    always @(posedge clk) begin
        bit xfer;
        int kind, hour;
        cyc++;
        xfer = started && rst_n && in_valid && m_ready;
        if (!rst_n) begin
            started    = 1'b1;
            m_ready    = 1'b1;
            m_ok       = 1'b0;
            m_err      = 1'b0;
            m_bin      = 5'd0;
            m_pm       = 1'b0;
            m_pend     = 1'b0;
            m_ready_at = 0;
        end else if (started) begin
            m_ok  = 1'b0;
            m_err = 1'b0;
            if (m_pend && cyc == m_ev_at) begin
                m_pend = 1'b0;
                if (m_pend_ok) begin
                    m_ok  = 1'b1;
                    m_bin = 5'(m_pend_hour);
                    m_pm  = (m_pend_hour >= 12);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (xfer) begin
                decode(hora_in, kind, hour);
                m_ev_at     = cyc + ((kind == 0) ? 3 : kind);
                m_ready_at  = m_ev_at + 1;
                m_pend      = 1'b1;
                m_pend_ok   = (kind == 0);
                m_pend_hour = hour;
            end
            m_ready = !m_pend && (cyc >= m_ready_at);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_in_ready", 32'(in_ready), 32'(m_ready));
            chk("model_hora_ok", 32'(hora_ok), 32'(m_ok));
            chk("model_err", 32'(err), 32'(m_err));
            chk("model_hora_bin", 32'(hora_bin), 32'(m_bin));
            chk("model_pm", 32'(pm), 32'(m_pm));
        end
    end

    // Called at a negedge; returns cycles from transfer to pulse (1 = first cycle after edge).
    task automatic send(input logic [7:0] b, output int lat, output int kind);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        hora_in  = b;
        @(negedge clk);
        in_valid = 1'b0;
        hora_in  = 8'($urandom);
        lat      = 1;
        kind     = 2;
        for (int i = 0; i < 20; i++) begin
            if (hora_ok) begin
                kind = 0;
                break;
            end
            if (err) begin
                kind = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_dir(input logic [7:0] b, input int ekind, input int elat,
                           input int ebin, input int epm);
        int lat, kind;
        send(b, lat, kind);
        chk($sformatf("dir_%02h_kind", b), 32'(kind), 32'(ekind));
        chk($sformatf("dir_%02h_lat", b), 32'(lat), 32'(elat));
        chk($sformatf("dir_%02h_bin", b), 32'(hora_bin), 32'(ebin));
        chk($sformatf("dir_%02h_pm", b), 32'(pm), 32'(epm));
        @(negedge clk);
    endtask

    initial begin
        int tx[2];
        int k;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        hora_in  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hora_bin", 32'(hora_bin), 32'd0);
        chk("rst_pm", 32'(pm), 32'd0);
        chk("rst_pulses", 32'({hora_ok, err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_dir(8'h23, 0, 4, 23, 1);
        run_dir(8'h52, 0, 4, 0, 0);
        run_dir(8'h72, 0, 4, 12, 1);
        run_dir(8'h61, 0, 4, 13, 1);
        run_dir(8'h49, 0, 4, 9, 0);
        run_dir(8'h24, 1, 3, 9, 0);
        run_dir(8'h1A, 1, 2, 9, 0);
        run_dir(8'h40, 1, 3, 9, 0);
        run_dir(8'h53, 1, 3, 9, 0);
        run_dir(8'hA3, 0, 4, 23, 1);
        run_dir(8'h30, 1, 2, 23, 1);
        run_dir(8'hE1, 0, 4, 13, 1);
        run_dir(8'h80, 0, 4, 0, 0);

        // Back-to-back: in_valid held high across two bytes.
        tx[0] = -100;
        tx[1] = -100;
        k = 0;
        in_valid = 1'b1;
        hora_in  = 8'h23;
        for (int n = 0; n < 30 && k < 2; n++) begin
            if (in_ready) begin
                tx[k] = n;
                k++;
            end
            @(negedge clk);
            if (k == 1) hora_in = 8'h05;
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(k), 32'd2);
        chk("b2b_gap", 32'(tx[1] - tx[0]), 32'd5);
        for (int i = 0; i < 10 && !hora_ok; i++) @(negedge clk);
        chk("b2b_bin", 32'(hora_bin), 32'd5);
        chk("b2b_ok", 32'(hora_ok), 32'd1);
        @(negedge clk);

        // Reset one edge after a transfer discards the byte.
        in_valid = 1'b1;
        hora_in  = 8'h23;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_pulse", 32'({hora_ok, err}), 32'd0);
            @(negedge clk);
        end
        chk("midrst_bin", 32'(hora_bin), 32'd0);
        chk("midrst_pm", 32'(pm), 32'd0);

        // Randomized traffic, mixing well-formed and arbitrary bytes, with rare resets.
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 149) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: hora_in = {1'($urandom), 1'b0, 2'($urandom_range(0, 2)),
                              4'($urandom_range(0, 9))};
                1: hora_in = {1'($urandom), 1'b1, 1'($urandom), 1'($urandom),
                              4'($urandom_range(0, 9))};
                default: hora_in = 8'($urandom);
            endcase
            @(negedge clk);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
